// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/master encodings and AXI response codes for mem_arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_e;
    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } master_e;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    function automatic master_e owner(input arb_state_e s);
        return (s == IFU_RD) ? MST_IFU : MST_LSU;
    endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational next-grant selection for mem_arbiter
//   ifu_req, lsu_rd_req, lsu_wr_req : pending requests seen in IDLE
//   last_grant                      : master granted most recently (round-robin only)
//   nxt                             : state to enter on the next edge (IDLE when nothing pending)
//   MEM_ARBITER_RR_EN defined selects round-robin between IFU and LSU, else LSU has fixed priority.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_rd_req,
    input  logic       lsu_wr_req,
    input  master_e    last_grant,
    output arb_state_e nxt
);
    logic       lsu_req;
    arb_state_e lsu_st;
    assign lsu_req = lsu_rd_req | lsu_wr_req;
    assign lsu_st  = lsu_rd_req ? LSU_RD : LSU_WR;
`ifdef MEM_ARBITER_RR_EN
    assign nxt = (lsu_req && ifu_req) ? ((last_grant == MST_LSU) ? IFU_RD : lsu_st) :
                 lsu_req ? lsu_st : ifu_req ? IFU_RD : IDLE;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign nxt = lsu_req ? lsu_st : ifu_req ? IFU_RD : IDLE;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU read-only, LSU read/write) AXI4-Lite arbiter onto one memory slave
//   clk, rst (async, active-low)
//   ifu_ar*/ifu_r*                         : IFU read master
//   lsu_ar*/lsu_r*/lsu_aw*/lsu_w*/lsu_b*   : LSU read/write master
//   slv_ar*/slv_r*/slv_aw*/slv_w*/slv_b*   : memory slave
//   gnt_state                              : current arbiter state (debug)
//   MEM_ARBITER_RR_EN defined selects round-robin arbitration, else fixed LSU > IFU.
// One whole transaction is in flight at a time; the granted master is wired straight through.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    input  logic                ifu_rready,
    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    input  logic                lsu_rready,
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    output logic                lsu_awready,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    input  logic                lsu_bready,
    output logic                slv_arvalid,
    output logic [ADDR_W-1:0]   slv_araddr,
    input  logic                slv_arready,
    input  logic                slv_rvalid,
    input  logic [DATA_W-1:0]   slv_rdata,
    input  logic [1:0]          slv_rresp,
    output logic                slv_rready,
    output logic                slv_awvalid,
    output logic [ADDR_W-1:0]   slv_awaddr,
    input  logic                slv_awready,
    output logic                slv_wvalid,
    output logic [DATA_W-1:0]   slv_wdata,
    output logic [DATA_W/8-1:0] slv_wstrb,
    input  logic                slv_wready,
    input  logic                slv_bvalid,
    input  logic [1:0]          slv_bresp,
    output logic                slv_bready,
    output logic [1:0]          gnt_state
);
    arb_state_e state, nxt;
    master_e    last_grant;
    logic       ar_done, aw_done, w_done;
    logic       st_ifu, st_lr, st_lw, done;

    arb_pick u_pick (
        .ifu_req    (ifu_arvalid),
        .lsu_rd_req (lsu_arvalid),
        .lsu_wr_req (lsu_awvalid | lsu_wvalid),
        .last_grant (last_grant),
        .nxt        (nxt)
    );

    assign st_ifu    = state == IFU_RD;
    assign st_lr     = state == LSU_RD;
    assign st_lw     = state == LSU_WR;
    assign gnt_state = state;

    // Address/data phases are closed once handshaken so a master cannot open a second transaction early.
    assign slv_arvalid = ~ar_done & (st_ifu ? ifu_arvalid : st_lr & lsu_arvalid);
    assign slv_araddr  = st_ifu ? ifu_araddr : st_lr ? lsu_araddr : '0;
    assign slv_rready  = st_ifu ? ifu_rready : st_lr & lsu_rready;
    assign slv_awvalid = st_lw & ~aw_done & lsu_awvalid;
    assign slv_awaddr  = st_lw ? lsu_awaddr : '0;
    assign slv_wvalid  = st_lw & ~w_done & lsu_wvalid;
    assign slv_wdata   = st_lw ? lsu_wdata : '0;
    assign slv_wstrb   = st_lw ? lsu_wstrb : '0;
    assign slv_bready  = st_lw & lsu_bready;

    assign ifu_arready = st_ifu & ~ar_done & slv_arready;
    assign ifu_rvalid  = st_ifu & slv_rvalid;
    assign ifu_rdata   = st_ifu ? slv_rdata : '0;
    assign ifu_rresp   = st_ifu ? slv_rresp : '0;
    assign lsu_arready = st_lr & ~ar_done & slv_arready;
    assign lsu_rvalid  = st_lr & slv_rvalid;
    assign lsu_rdata   = st_lr ? slv_rdata : '0;
    assign lsu_rresp   = st_lr ? slv_rresp : '0;
    assign lsu_awready = st_lw & ~aw_done & slv_awready;
    assign lsu_wready  = st_lw & ~w_done & slv_wready;
    assign lsu_bvalid  = st_lw & slv_bvalid;
    assign lsu_bresp   = st_lw ? slv_bresp : '0;

    // slv_rready/slv_bready are already zero outside the matching states.
    assign done = (slv_rvalid & slv_rready) | (slv_bvalid & slv_bready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= MST_IFU;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else if (state == IDLE) begin
            state <= nxt;
            if (nxt != IDLE) last_grant <= owner(nxt);
        end else begin
            state   <= done ? IDLE : state;
            ar_done <= ~done & (ar_done | (slv_arvalid & slv_arready));
            aw_done <= ~done & (aw_done | (slv_awvalid & slv_awready));
            w_done  <= ~done & (w_done | (slv_wvalid & slv_wready));
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;
    logic        slv_arvalid, slv_arready, slv_rvalid, slv_rready;
    logic [31:0] slv_araddr, slv_rdata;
    logic [1:0]  slv_rresp;
    logic        slv_awvalid, slv_awready, slv_wvalid, slv_wready, slv_bvalid, slv_bready;
    logic [31:0] slv_awaddr, slv_wdata;
    logic [3:0]  slv_wstrb;
    logic [1:0]  slv_bresp;
    logic [1:0]  gnt_state;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .slv_arvalid(slv_arvalid), .slv_araddr(slv_araddr), .slv_arready(slv_arready),
        .slv_rvalid(slv_rvalid), .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rready(slv_rready),
        .slv_awvalid(slv_awvalid), .slv_awaddr(slv_awaddr), .slv_awready(slv_awready),
        .slv_wvalid(slv_wvalid), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_wready(slv_wready),
        .slv_bvalid(slv_bvalid), .slv_bresp(slv_bresp), .slv_bready(slv_bready),
        .gnt_state(gnt_state)
    );

    always #5 clk = ~clk;

    wire [35:0]  ifu_out = {ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp};
    wire [40:0]  lsu_out = {lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
                            lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp};
    wire [76:0]  m_out   = {ifu_out, lsu_out};
    wire [104:0] s_out   = {slv_arvalid, slv_araddr, slv_rready, slv_awvalid, slv_awaddr,
                            slv_wvalid, slv_wdata, slv_wstrb, slv_bready};

    // Masters must hold arvalid until accepted.
    assert property (@(posedge clk) disable iff (!rst) (ifu_arvalid && !ifu_arready) |=> ifu_arvalid)
        else $error("ifu_arvalid dropped before handshake");
    assert property (@(posedge clk) disable iff (!rst) (lsu_arvalid && !lsu_arready) |=> lsu_arvalid)
        else $error("lsu_arvalid dropped before handshake");

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered in the first cycle of a read grant; leaves in the following IDLE bubble.
    task automatic serve_rd(input string tag, input arb_state_e st, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] resp, input int lat);
        logic is_ifu;
        is_ifu = (st == IFU_RD);
        check({tag, "_gnt"}, gnt_state, st);
        check({tag, "_araddr"}, {slv_arvalid, slv_araddr}, {1'b1, addr});
        slv_arready = 1'b1;
        #1;
        check({tag, "_arready"}, {ifu_arready, lsu_arready}, is_ifu ? 2'b10 : 2'b01);
        tick;
        if (is_ifu) ifu_arvalid = 1'b0; else lsu_arvalid = 1'b0;
        slv_arready = 1'b0;
        repeat (lat) tick;
        slv_rvalid = 1'b1;
        slv_rdata  = data;
        slv_rresp  = resp;
        #1;
        check({tag, "_rvalid"}, {ifu_rvalid, lsu_rvalid}, is_ifu ? 2'b10 : 2'b01);
        check({tag, "_rdata"}, is_ifu ? {ifu_rresp, ifu_rdata} : {lsu_rresp, lsu_rdata}, {resp, data});
        check({tag, "_other"}, is_ifu ? {87'b0, lsu_out} : {92'b0, ifu_out}, 128'b0);
        tick;
        slv_rvalid = 1'b0;
        slv_rdata  = '0;
        slv_rresp  = '0;
        #1;
        check({tag, "_idle"}, gnt_state, IDLE);
    endtask

    initial begin
        rst = 1'b0;
        {ifu_arvalid, ifu_araddr, ifu_rready} = '0;
        {lsu_arvalid, lsu_araddr, lsu_rready} = '0;
        {lsu_awvalid, lsu_awaddr, lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_bready} = '0;
        {slv_arready, slv_rvalid, slv_rdata, slv_rresp} = '0;
        {slv_awready, slv_wready, slv_bvalid, slv_bresp} = '0;
        tick;
        tick;
        check("rst_gnt", gnt_state, IDLE);
        check("rst_mst", m_out, 0);
        check("rst_slv", s_out, 0);
        rst = 1'b1;
        tick;

        // IFU alone, slave answers three cycles after the address is first offered
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        ifu_rready  = 1'b1;
        #1;
        check("t1_req_gnt", gnt_state, IDLE);
        check("t1_req_slv", s_out, 0);
        tick;
        serve_rd("t1", IFU_RD, 32'h8000_0000, 32'h0000_0413, OKAY, 2);

        // same-cycle conflict, then LSU re-requests during the bubble
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0100;
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1000;
        lsu_rready  = 1'b1;
        tick;
        serve_rd("c1", LSU_RD, 32'h8000_1000, 32'h1111_1111, OKAY, 0);
        check("c1_ifu_wait", ifu_arready, 1'b0);
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1004;
        tick;
`ifdef MEM_ARBITER_RR_EN
        serve_rd("c2", IFU_RD, 32'h8000_0100, 32'h2222_2222, OKAY, 0);
        tick;
        serve_rd("c3", LSU_RD, 32'h8000_1004, 32'h3333_3333, OKAY, 0);
`else
        serve_rd("c2", LSU_RD, 32'h8000_1004, 32'h3333_3333, OKAY, 0);
        tick;
        serve_rd("c3", IFU_RD, 32'h8000_0100, 32'h2222_2222, OKAY, 0);
`endif

        // LSU write, W offered one cycle before AW; IFU arrives mid-write
        lsu_wvalid = 1'b1;
        lsu_wdata  = 32'hDEAD_BEEF;
        lsu_wstrb  = 4'hF;
        lsu_bready = 1'b1;
        #1;
        check("w_idle_slv", s_out, 0);
        tick;
        check("w_gnt", gnt_state, LSU_WR);
        slv_wready  = 1'b1;
        lsu_awvalid = 1'b1;
        lsu_awaddr  = 32'h8000_2004;
        #1;
        check("w_slv_w", {slv_wvalid, slv_wdata, slv_wstrb}, {1'b1, 32'hDEAD_BEEF, 4'hF});
        check("w_wready", lsu_wready, 1'b1);
        check("w_slv_aw", {slv_awvalid, slv_awaddr}, {1'b1, 32'h8000_2004});
        tick;
        lsu_wvalid  = 1'b0;
        lsu_wdata   = '0;
        lsu_wstrb   = '0;
        slv_wready  = 1'b0;
        slv_awready = 1'b1;
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0010;
        #1;
        check("w_awready", lsu_awready, 1'b1);
        check("w_ifu_blocked", {ifu_arready, slv_arvalid}, 2'b00);
        tick;
        lsu_awvalid = 1'b0;
        slv_awready = 1'b0;
        slv_bvalid  = 1'b1;
        slv_bresp   = OKAY;
        #1;
        check("w_bresp", {lsu_bvalid, lsu_bresp}, {1'b1, OKAY});
        check("w_b_gnt", gnt_state, LSU_WR);
        check("w_b_ifu", ifu_arready, 1'b0);
        tick;
        slv_bvalid = 1'b0;
        #1;
        check("w_idle", gnt_state, IDLE);
        tick;
        serve_rd("w_ifu", IFU_RD, 32'h8000_0010, 32'h4444_4444, OKAY, 0);

        // SLVERR to LSU does not disturb sequencing; pending IFU follows
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1008;
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0014;
        tick;
        serve_rd("err", LSU_RD, 32'h8000_1008, 32'h5555_5555, SLVERR, 1);
        tick;
        serve_rd("err_ifu", IFU_RD, 32'h8000_0014, 32'h6666_6666, OKAY, 0);

        // reset between AR handshake and rvalid
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_100C;
        tick;
        check("r_gnt", gnt_state, LSU_RD);
        slv_arready = 1'b1;
        tick;
        lsu_arvalid = 1'b0;
        slv_arready = 1'b0;
        #1;
        check("r_pre_rready", slv_rready, 1'b1);
        #2;
        rst = 1'b0;
        {slv_arready, slv_rvalid, slv_awready, slv_wready, slv_bvalid} = '1;
        slv_rdata = 32'hFFFF_FFFF;
        #1;
        check("r_gnt0", gnt_state, IDLE);
        check("r_mst0", m_out, 0);
        check("r_slv0", s_out, 0);
        tick;
        {slv_arready, slv_rvalid, slv_awready, slv_wready, slv_bvalid} = '0;
        slv_rdata = '0;
        rst = 1'b1;
        tick;
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0020;
        tick;
        serve_rd("post", IFU_RD, 32'h8000_0020, 32'h7777_7777, OKAY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave AXI4-Lite arbiter sharing the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store path (LSU, read and write). It sits between the core's bus masters and the memory slave. It serialises whole transactions (address through response) so that at most one transaction is outstanding on the slave. All bursts are single-beat.

## Interface
Parameters:
- ADDR_W, 32, address width on all channels
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports (channel bundles follow AXI4-Lite naming, e.g. `lsu_awvalid`/`lsu_awready`/`lsu_awaddr`):
- clk  in  1  single clock; all state on posedge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- ifu_ar{valid,addr} in / ifu_arready out  1/ADDR_W/1  IFU read address
- ifu_r{valid,data,resp} out / ifu_rready in  1/DATA_W/2/1  IFU read data
- lsu_ar{valid,addr} in / lsu_arready out  LSU read address
- lsu_r{valid,data,resp} out / lsu_rready in  LSU read data
- lsu_aw{valid,addr} in / lsu_awready out  LSU write address
- lsu_w{valid,data,strb} in / lsu_wready out  1/DATA_W/DATA_W/8  LSU write data
- lsu_b{valid,resp} out / lsu_bready in  LSU write response
- slv_ar*, slv_r*, slv_aw*, slv_w*, slv_b*  mirror directions  the slave side
- gnt_state  out  2  current arbiter state, for debug

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR.
- Requests, sampled only in IDLE:
  - ifu_req = ifu_arvalid
  - lsu_rd_req = lsu_arvalid
  - lsu_wr_req = lsu_awvalid | lsu_wvalid
- LSU internal priority: lsu_rd_req over lsu_wr_req.
- IDLE transitions, without the Configuration macro:
  - lsu_rd_req → LSU_RD
  - else lsu_wr_req → LSU_WR
  - else ifu_req → IFU_RD
- In a granted state, all channels of the granted master connect combinationally to the slave, in both directions.
- Non-granted master: its ready and valid outputs are 0 and its data/resp outputs are 0.
- Slave side in IDLE: all slave valid/ready inputs are driven 0 and payloads are 0.
- Completion returns to IDLE:
  - IFU_RD: on `slv_rvalid & ifu_rready`
  - LSU_RD: on `slv_rvalid & lsu_rready`
  - LSU_WR: on `slv_bvalid & lsu_bready`
- AW and W pass through independently in LSU_WR. Either may handshake first. Completion waits only on B.
- rresp/bresp are forwarded unchanged; error responses do not alter sequencing.

## Timing
- Arbitration is registered. A request seen in IDLE at edge N grants at N+1. The earliest slave arvalid/awvalid is cycle N+1.
- The grant is held until completion. No pre-emption occurs and requests arriving mid-transaction wait.
- The response handshake cycle ends the grant. IDLE follows on the next edge, so back-to-back transactions have a minimum 1-cycle bubble.
- Masters hold valid and payload until ready, per AXI. The arbiter adds no buffering.
- Simultaneous IFU and LSU requests in IDLE are resolved by the priority rule; the loser's arvalid stays pending.
- Reset (rst=0) has immediate effect:
  - state → IDLE, gnt_state=0
  - all valid/ready outputs 0 and all payload outputs 0
  - any in-flight slave transaction is abandoned; the slave shares the same reset.
- A valid that deasserts before its handshake in IDLE is a protocol violation. The behaviour is undefined and is asserted against in the bench.

## Configuration
- `MEM_ARBITER_RR_EN` undefined: fixed priority LSU > IFU, as in Operation.
- `MEM_ARBITER_RR_EN` defined: round-robin between IFU and LSU.
  - A 1-bit last_grant register updates on every grant and resets to IFU.
  - On a conflict, the master not granted last wins.
  - A lone requester is always granted.
  - LSU read-before-write ordering is unchanged.

## Structure
- Package `mem_arbiter_pkg`:
  - `arb_state_e` with IDLE=2'd0, IFU_RD=2'd1, LSU_RD=2'd2, LSU_WR=2'd3
  - `master_e` with MST_IFU=0, MST_LSU=1
  - the AXI resp constants OKAY=2'b00 and SLVERR=2'b10
- One sub-module, `arb_pick`: combinational next-grant selection from the requests and last_grant (last_grant is ignored unless RR is enabled). Muxing and the FSM stay in `mem_arbiter`.

## Test plan
- IFU alone: araddr=0x8000_0000, slave rdata=0x0000_0413 after 3 cycles → ifu_rdata=0x0000_0413, gnt_state IDLE→IFU_RD→IDLE, lsu_* outputs stay 0.
- Conflict in the same cycle: IFU arvalid plus LSU arvalid (0x8000_1000). Fixed mode → LSU served first, then IFU after a 1-cycle bubble. RR mode, the first conflict after reset → LSU, the second conflict → IFU.
- LSU write with W before AW: wdata=0xDEAD_BEEF and wstrb=0xF one cycle before awaddr=0x8000_2004 → slave sees both, bresp=OKAY → lsu_bvalid=1 and return to IDLE.
- Slave returns rresp=SLVERR to LSU → lsu_rresp=2'b10, the FSM completes normally, and a pending IFU request is granted next.
- IFU request arrives during LSU_WR → ifu_arready=0 until the B handshake completes, then IFU_RD.
- rst driven to 0 mid-LSU_RD (between the AR handshake and rvalid) → all valid/ready outputs 0 in the same cycle, gnt_state=0; normal operation resumes after release.
